striping_2lanes: RTL and testbench
==================================

# striping_2lanes

Two-lane byte-striping stage that sits directly downstream of the recirculation stage. It consumes the 32-bit word stream `data_out_Recir`/`valid_out_Recir` on `clk_2f` and deals words alternately onto lane 0 and lane 1, each lane running at an effective clk_f rate. It tracks lane pairing, raises `active` once the first complete pair is delivered, and flags a broken pair when a lane-1 word fails to arrive within a bounded idle window.

## Interface
Parameters:
- `DATA_WIDTH`, 32, word width on input and both lanes
- `IDLE_LIMIT`, 4, number of consecutive non-valid cycles tolerated in S_L1 before the pair is declared broken (range 1–255)

Ports:
- `clk_2f`  input  1  single clock for all state; all state changes occur on its rising edge
- `reset_L`  input  1  asynchronous, active-high reset (1 = reset)
- `valid_in`  input  1  input word qualifier, from `valid_out_Recir`
- `data_in`  input  DATA_WIDTH  input word, from `data_out_Recir`
- `valid_out_lane0`  output  1  one-cycle pulse, lane 0 word valid
- `data_out_lane0`  output  DATA_WIDTH  lane 0 word, held until next lane 0 write
- `valid_out_lane1`  output  1  one-cycle pulse, lane 1 word valid
- `data_out_lane1`  output  DATA_WIDTH  lane 1 word, held until next lane 1 write
- `active`  output  1  high once a first full pair has been striped
- `pair_err`  output  1  one-cycle pulse on lane-1 timeout
- `word_count`  output  8  count of accepted words, wraps 255→0

## Operation
- Reset values: all data outputs 0, all valids 0, `active` 0, `pair_err` 0, `word_count` 0, idle counter 0, state S_L0.
- State S_L0 (next word goes to lane 0):
  - `valid_in`=1 → register `data_in` into lane 0, pulse `valid_out_lane0`, go to S_L1, clear idle counter.
  - `valid_in`=0 → stay; idle counter not used.
- State S_L1 (next word goes to lane 1):
  - `valid_in`=1 → register into lane 1, pulse `valid_out_lane1`, set `active`=1 (sticky), go to S_L0, clear idle counter.
  - `valid_in`=0 → idle counter increments.
  - When the idle counter reaches `IDLE_LIMIT`: pulse `pair_err`, clear the counter, return to S_L0. Lane 1 is not written; `active` is unchanged.
- Timeout versus valid in the same cycle: valid wins. If `valid_in`=1 in the cycle the counter would reach the limit, the word goes to lane 1 and there is no error.
- `word_count` increments by 1 on every accepted word (`valid_in`=1), modulo 256. It is not affected by `pair_err`.
- `data_in` is ignored when `valid_in`=0. Lane data registers hold their last value.
- Both lane valids are never high in the same cycle.
- Only `reset_L` clears `active`.

## Timing
- Latency is 1 cycle. A word sampled on edge k appears on its lane output, with its valid pulse, after edge k; valid is high for exactly cycle k→k+1.
- Throughput: one word per `clk_2f` cycle. Back-to-back valids give lane pulses on alternating cycles, so each lane effectively runs at the clk_f rate.
- Timeout: entering S_L1 after edge k with no further valid gives `pair_err` high in the cycle following edge k+`IDLE_LIMIT`, and the state is S_L0 from that same edge.
- Reset mid-operation: assertion clears everything immediately, without waiting for a clock edge. After deassertion, the first valid word always goes to lane 0.

## Test plan
1. Reset then stream 0xA0000001..0xA0000004, back to back: lane 0 gets ..01 and ..03, lane 1 gets ..02 and ..04, each one cycle after input. `active` rises with the ..02 pulse; `word_count` reaches 4.
2. Gapped stream: 0x11 valid, 2 idle cycles, 0x22 valid (`IDLE_LIMIT`=4): 0x22 lands on lane 1 and `pair_err` stays 0.
3. Timeout: 0x33 valid, then 4 idle cycles: `pair_err` pulses once, state returns to S_L0, and the next word 0x44 goes to lane 0. `active` stays 0 if no pair has completed yet.
4. Limit collision: 0x55, 3 idle cycles, then 0x66 valid on the 4th cycle: 0x66 goes to lane 1 and there is no `pair_err`.
5. Wrap: 257 valid words: `word_count` goes 255→0→1; the lane assignment continues alternating without a glitch.
6. Asynchronous reset asserted between clock edges while in S_L1 with `active`=1: all outputs are 0 immediately. After release, word 0x77 goes to lane 0.

Source files
------------

// File: rtl/striping_2lanes.sv
// Two-lane word striper: deals an incoming word stream alternately onto lane 0 and lane 1,
// tracks pairing, and flags a broken pair when lane 1 starves for IDLE_LIMIT cycles.
module striping_2lanes #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned IDLE_LIMIT = 4
) (
   input  logic                  clk_2f,
   input  logic                  reset_L,
   input  logic                  valid_in,
   input  logic [DATA_WIDTH-1:0] data_in,
   output logic                  valid_out_lane0,
   output logic [DATA_WIDTH-1:0] data_out_lane0,
   output logic                  valid_out_lane1,
   output logic [DATA_WIDTH-1:0] data_out_lane1,
   output logic                  active,
   output logic                  pair_err,
   output logic [7:0]            word_count
);

   localparam logic [0:0] S_L0 = 1'b0;
   localparam logic [0:0] S_L1 = 1'b1;

   // Counter value on the edge that would complete the idle window
   localparam logic [7:0] IDLE_LAST = 8'(IDLE_LIMIT - 1);

   logic [0:0] state;
   logic [7:0] idle_cnt;

   always_ff @(posedge clk_2f or posedge reset_L) begin
      if (reset_L) begin
         state           <= S_L0;
         idle_cnt        <= '0;
         valid_out_lane0 <= 1'b0;
         valid_out_lane1 <= 1'b0;
         data_out_lane0  <= '0;
         data_out_lane1  <= '0;
         active          <= 1'b0;
         pair_err        <= 1'b0;
         word_count      <= '0;
      end else begin
         valid_out_lane0 <= 1'b0;
         valid_out_lane1 <= 1'b0;
         pair_err        <= 1'b0;

         if (valid_in)
            word_count <= word_count + 8'd1;

         case (state)
            S_L0: begin
               if (valid_in) begin
                  data_out_lane0  <= data_in;
                  valid_out_lane0 <= 1'b1;
                  idle_cnt        <= '0;
                  state           <= S_L1;
               end
            end
            S_L1: begin
               // A valid word always beats the timeout on the same edge
               if (valid_in) begin
                  data_out_lane1  <= data_in;
                  valid_out_lane1 <= 1'b1;
                  active          <= 1'b1;
                  idle_cnt        <= '0;
                  state           <= S_L0;
               end else if (idle_cnt == IDLE_LAST) begin
                  pair_err <= 1'b1;
                  idle_cnt <= '0;
                  state    <= S_L0;
               end else begin
                  idle_cnt <= idle_cnt + 8'd1;
               end
            end
            default: state <= S_L0;
         endcase
      end
   end

endmodule

// File: tb/tb_striping_2lanes.sv
// Directed-vector bench for striping_2lanes with hand-computed expectations.
module tb_striping_2lanes;

   logic        clk_2f;
   logic        reset_L;
   logic        valid_in;
   logic [31:0] data_in;
   logic        valid_out_lane0;
   logic [31:0] data_out_lane0;
   logic        valid_out_lane1;
   logic [31:0] data_out_lane1;
   logic        active;
   logic        pair_err;
   logic [7:0]  word_count;

   int checks = 0;
   int errors = 0;

   striping_2lanes #(.DATA_WIDTH(32), .IDLE_LIMIT(4)) dut (
      .clk_2f          (clk_2f),
      .reset_L         (reset_L),
      .valid_in        (valid_in),
      .data_in         (data_in),
      .valid_out_lane0 (valid_out_lane0),
      .data_out_lane0  (data_out_lane0),
      .valid_out_lane1 (valid_out_lane1),
      .data_out_lane1  (data_out_lane1),
      .active          (active),
      .pair_err        (pair_err),
      .word_count      (word_count)
   );

   initial clk_2f = 1'b0;
   always #5 clk_2f = ~clk_2f;

   task automatic step();
      @(posedge clk_2f);
      #1;
   endtask

   task automatic do_reset();
      valid_in = 1'b0;
      data_in  = '0;
      reset_L  = 1'b1;
      step();
      #2;
      reset_L = 1'b0;
   endtask

   task automatic test_reset();
      reset_L  = 1'b1;
      valid_in = 1'b0;
      data_in  = 32'hDEAD_BEEF;
      #12;
      checks++;
      if ({valid_out_lane0, valid_out_lane1, active, pair_err} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_flags got %b expected 0000", {valid_out_lane0, valid_out_lane1, active, pair_err});
      end
      checks++;
      if ({data_out_lane0, data_out_lane1, word_count} !== 72'd0) begin
         errors++;
         $display("FAIL reset_data got d0=%h d1=%h wc=%0d expected all 0", data_out_lane0, data_out_lane1, word_count);
      end
      #1;
      reset_L = 1'b0;
   endtask

   task automatic test_stream();
      logic [31:0] words [4];
      words = '{32'hA000_0001, 32'hA000_0002, 32'hA000_0003, 32'hA000_0004};
      for (int i = 0; i < 4; i++) begin
         valid_in = 1'b1;
         data_in  = words[i];
         step();
         checks++;
         if (i % 2 == 0) begin
            if (valid_out_lane0 !== 1'b1 || valid_out_lane1 !== 1'b0 || data_out_lane0 !== words[i]) begin
               errors++;
               $display("FAIL stream_lane0[%0d] got v0=%b v1=%b d0=%h expected v0=1 v1=0 d0=%h",
                        i, valid_out_lane0, valid_out_lane1, data_out_lane0, words[i]);
            end
         end else begin
            if (valid_out_lane1 !== 1'b1 || valid_out_lane0 !== 1'b0 || data_out_lane1 !== words[i]) begin
               errors++;
               $display("FAIL stream_lane1[%0d] got v0=%b v1=%b d1=%h expected v0=0 v1=1 d1=%h",
                        i, valid_out_lane0, valid_out_lane1, data_out_lane1, words[i]);
            end
         end
         checks++;
         if (active !== (i >= 1)) begin
            errors++;
            $display("FAIL stream_active[%0d] got %b expected %b", i, active, (i >= 1));
         end
         checks++;
         if (word_count !== 8'(i + 1)) begin
            errors++;
            $display("FAIL stream_count[%0d] got %0d expected %0d", i, word_count, i + 1);
         end
      end
      valid_in = 1'b0;
      data_in  = 32'hFFFF_FFFF;
      step();
      checks++;
      if (valid_out_lane0 !== 1'b0 || valid_out_lane1 !== 1'b0 ||
          data_out_lane0 !== 32'hA000_0003 || data_out_lane1 !== 32'hA000_0004) begin
         errors++;
         $display("FAIL stream_hold got v0=%b v1=%b d0=%h d1=%h expected 0 0 a0000003 a0000004",
                  valid_out_lane0, valid_out_lane1, data_out_lane0, data_out_lane1);
      end
   endtask

   task automatic test_gap();
      valid_in = 1'b1;
      data_in  = 32'h11;
      step();
      checks++;
      if (valid_out_lane0 !== 1'b1 || data_out_lane0 !== 32'h11) begin
         errors++;
         $display("FAIL gap_first got v0=%b d0=%h expected 1 00000011", valid_out_lane0, data_out_lane0);
      end
      valid_in = 1'b0;
      for (int i = 0; i < 2; i++) begin
         step();
         checks++;
         if (pair_err !== 1'b0) begin
            errors++;
            $display("FAIL gap_idle_err[%0d] got %b expected 0", i, pair_err);
         end
      end
      valid_in = 1'b1;
      data_in  = 32'h22;
      step();
      checks++;
      if (valid_out_lane1 !== 1'b1 || data_out_lane1 !== 32'h22 || pair_err !== 1'b0 || valid_out_lane0 !== 1'b0) begin
         errors++;
         $display("FAIL gap_second got v0=%b v1=%b d1=%h err=%b expected 0 1 00000022 0",
                  valid_out_lane0, valid_out_lane1, data_out_lane1, pair_err);
      end
      checks++;
      if (word_count !== 8'd6) begin
         errors++;
         $display("FAIL gap_count got %0d expected 6", word_count);
      end
      valid_in = 1'b0;
   endtask

   task automatic test_collision();
      valid_in = 1'b1;
      data_in  = 32'h55;
      step();
      valid_in = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (pair_err !== 1'b0) begin
            errors++;
            $display("FAIL collide_idle_err[%0d] got %b expected 0", i, pair_err);
         end
      end
      valid_in = 1'b1;
      data_in  = 32'h66;
      step();
      checks++;
      if (valid_out_lane1 !== 1'b1 || data_out_lane1 !== 32'h66 || pair_err !== 1'b0) begin
         errors++;
         $display("FAIL collide_lane1 got v1=%b d1=%h err=%b expected 1 00000066 0",
                  valid_out_lane1, data_out_lane1, pair_err);
      end
      valid_in = 1'b0;
      step();
      checks++;
      if (pair_err !== 1'b0) begin
         errors++;
         $display("FAIL collide_after_err got %b expected 0", pair_err);
      end
   endtask

   task automatic test_timeout();
      do_reset();
      valid_in = 1'b1;
      data_in  = 32'h33;
      step();
      valid_in = 1'b0;
      data_in  = 32'hFFFF_FFFF;
      for (int i = 1; i <= 5; i++) begin
         step();
         checks++;
         if (pair_err !== (i == 4)) begin
            errors++;
            $display("FAIL timeout_err[%0d] got %b expected %b", i, pair_err, (i == 4));
         end
      end
      checks++;
      if (active !== 1'b0 || valid_out_lane1 !== 1'b0 || data_out_lane1 !== 32'h0) begin
         errors++;
         $display("FAIL timeout_lane1 got active=%b v1=%b d1=%h expected 0 0 00000000",
                  active, valid_out_lane1, data_out_lane1);
      end
      valid_in = 1'b1;
      data_in  = 32'h44;
      step();
      checks++;
      if (valid_out_lane0 !== 1'b1 || valid_out_lane1 !== 1'b0 || data_out_lane0 !== 32'h44) begin
         errors++;
         $display("FAIL timeout_next got v0=%b v1=%b d0=%h expected 1 0 00000044",
                  valid_out_lane0, valid_out_lane1, data_out_lane0);
      end
      checks++;
      if (word_count !== 8'd2) begin
         errors++;
         $display("FAIL timeout_count got %0d expected 2", word_count);
      end
      valid_in = 1'b0;
   endtask

   task automatic test_wrap();
      do_reset();
      for (int i = 0; i < 257; i++) begin
         valid_in = 1'b1;
         data_in  = 32'(i) + 32'h100;
         step();
         checks++;
         if (word_count !== 8'((i + 1) % 256)) begin
            errors++;
            $display("FAIL wrap_count[%0d] got %0d expected %0d", i, word_count, (i + 1) % 256);
         end
         checks++;
         if (i % 2 == 0) begin
            if (valid_out_lane0 !== 1'b1 || valid_out_lane1 !== 1'b0 || data_out_lane0 !== 32'(i) + 32'h100) begin
               errors++;
               $display("FAIL wrap_lane0[%0d] got v0=%b v1=%b d0=%h", i, valid_out_lane0, valid_out_lane1, data_out_lane0);
            end
         end else begin
            if (valid_out_lane1 !== 1'b1 || valid_out_lane0 !== 1'b0 || data_out_lane1 !== 32'(i) + 32'h100) begin
               errors++;
               $display("FAIL wrap_lane1[%0d] got v0=%b v1=%b d1=%h", i, valid_out_lane0, valid_out_lane1, data_out_lane1);
            end
         end
      end
      valid_in = 1'b0;
   endtask

   task automatic test_async_reset();
      checks++;
      if (active !== 1'b1) begin
         errors++;
         $display("FAIL async_pre_active got %b expected 1", active);
      end
      #3;
      reset_L = 1'b1;
      #1;
      checks++;
      if ({valid_out_lane0, valid_out_lane1, active, pair_err} !== 4'b0000 ||
          data_out_lane0 !== 32'h0 || data_out_lane1 !== 32'h0 || word_count !== 8'd0) begin
         errors++;
         $display("FAIL async_reset got v0=%b v1=%b act=%b err=%b d0=%h d1=%h wc=%0d expected all 0",
                  valid_out_lane0, valid_out_lane1, active, pair_err, data_out_lane0, data_out_lane1, word_count);
      end
      @(posedge clk_2f);
      #2;
      reset_L = 1'b0;
      valid_in = 1'b1;
      data_in  = 32'h77;
      step();
      checks++;
      if (valid_out_lane0 !== 1'b1 || valid_out_lane1 !== 1'b0 || data_out_lane0 !== 32'h77) begin
         errors++;
         $display("FAIL async_first got v0=%b v1=%b d0=%h expected 1 0 00000077",
                  valid_out_lane0, valid_out_lane1, data_out_lane0);
      end
      valid_in = 1'b0;
   endtask

   initial begin
      test_reset();
      test_stream();
      test_gap();
      test_collision();
      test_timeout();
      test_wrap();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
